// File: rtl/interp_pkg.sv
// Shared widths and state encoding for the interpolation table reader.
package interp_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int FRAC_W = 16;
  localparam int CNT_W  = 16;
  localparam int LANE_W = DATA_W / 2;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_A,
    FETCH_B,
    WAIT_B,
    CALC,
    OUT,
    DONE
  } state_e;

endpackage

// File: rtl/interp_lerp_lane.sv
// One signed lane of linear interpolation: y = a + floor((b - a) * frac / 2**FRAC_W).
module interp_lerp_lane #(
  parameter int LANE_W = 16,
  parameter int FRAC_W = 16
) (
  input  logic [LANE_W-1:0] a_i,
  input  logic [LANE_W-1:0] b_i,
  input  logic [FRAC_W-1:0] frac_i,
  output logic [LANE_W-1:0] y_o
);

  logic signed [LANE_W:0]          diff;
  logic signed [LANE_W+FRAC_W+1:0] prod;

  assign diff = $signed({b_i[LANE_W-1], b_i}) - $signed({a_i[LANE_W-1], a_i});
  assign prod = diff * $signed({1'b0, frac_i});
  // frac < 1 keeps the result between a and b, so truncating back to the lane width is exact.
  assign y_o  = a_i + LANE_W'(prod >>> FRAC_W);

endmodule

// File: rtl/interpolation_lerp_reader.sv
// Walks a fractional phase over a circular {I,Q} sample table and streams
// linearly interpolated samples; drives a 1-cycle-latency RAM read port.
module interpolation_lerp_reader
  import interp_pkg::*;
#(
  parameter int ADDR_W = interp_pkg::ADDR_W,
  parameter int DATA_W = interp_pkg::DATA_W,
  parameter int FRAC_W = interp_pkg::FRAC_W,
  parameter int CNT_W  = interp_pkg::CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic [ADDR_W+FRAC_W-1:0] start_phase_i,
  input  logic [ADDR_W+FRAC_W-1:0] step_i,
  input  logic [CNT_W-1:0]         num_out_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [ADDR_W-1:0]        rd_addr_o,
  input  logic [DATA_W-1:0]        rd_data_i,
  output logic [DATA_W-1:0]        out_data_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic                     out_last_o
);

  localparam int PHASE_W = ADDR_W + FRAC_W;
  localparam int LANE_W  = DATA_W / 2;

  state_e               state_q, state_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [PHASE_W-1:0]   step_q, step_d;
  logic [CNT_W-1:0]     remain_q, remain_d;
  logic [DATA_W-1:0]    a_q, a_d;
  logic [DATA_W-1:0]    b_q, b_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;
  logic                 out_last_q, out_last_d;
  logic [ADDR_W-1:0]    rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]    lerp;
  logic [PHASE_W-1:0]   phase_next;

  assign phase_next = phase_q + step_q;

  interp_lerp_lane #(.LANE_W(LANE_W), .FRAC_W(FRAC_W)) u_lane_i (
    .a_i    (a_q[DATA_W-1:LANE_W]),
    .b_i    (b_q[DATA_W-1:LANE_W]),
    .frac_i (phase_q[FRAC_W-1:0]),
    .y_o    (lerp[DATA_W-1:LANE_W])
  );

  interp_lerp_lane #(.LANE_W(LANE_W), .FRAC_W(FRAC_W)) u_lane_q (
    .a_i    (a_q[LANE_W-1:0]),
    .b_i    (b_q[LANE_W-1:0]),
    .frac_i (phase_q[FRAC_W-1:0]),
    .y_o    (lerp[LANE_W-1:0])
  );

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    step_d     = step_q;
    remain_d   = remain_q;
    a_d        = a_q;
    b_d        = b_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    rd_addr_d  = rd_addr_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          phase_d   = start_phase_i;
          step_d    = step_i;
          remain_d  = num_out_i;
          rd_addr_d = start_phase_i[PHASE_W-1:FRAC_W];
          state_d   = (num_out_i == '0) ? DONE : FETCH_A;
        end
      end
      FETCH_A: begin
        rd_addr_d = phase_q[PHASE_W-1:FRAC_W] + ADDR_W'(1);
        state_d   = FETCH_B;
      end
      FETCH_B: begin
        a_d     = rd_data_i;
        state_d = WAIT_B;
      end
      WAIT_B: begin
        b_d     = rd_data_i;
        state_d = CALC;
      end
      CALC: begin
        out_data_d = lerp;
        out_last_d = (remain_q == CNT_W'(1));
        state_d    = OUT;
      end
      OUT: begin
        // Address for the next sample is staged here so FETCH_A presents it directly.
        if (out_ready_i) begin
          phase_d    = phase_next;
          remain_d   = remain_q - CNT_W'(1);
          rd_addr_d  = phase_next[PHASE_W-1:FRAC_W];
          out_last_d = 1'b0;
          state_d    = (remain_q == CNT_W'(1)) ? DONE : FETCH_A;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      step_q     <= '0;
      remain_q   <= '0;
      a_q        <= '0;
      b_q        <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      rd_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      step_q     <= step_d;
      remain_q   <= remain_d;
      a_q        <= a_d;
      b_q        <= b_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  assign busy_o      = (state_q != IDLE) && (state_q != DONE);
  assign done_o      = (state_q == DONE);
  assign out_valid_o = (state_q == OUT);
  assign out_last_o  = out_last_q;
  assign out_data_o  = out_data_q;
  assign rd_addr_o   = rd_addr_q;

endmodule

// File: doc/interpolation_lerp_reader.md
Name: interpolation_lerp_reader

Overview:
- Downstream consumer of the 1024x32 simple-dual-port interpolation RAM. Drives its read port; RAM read latency is 1 cycle with no output register.
- Walks a fractional phase accumulator across the stored sample table and emits linearly interpolated I/Q samples on a valid/ready stream.
- Each RAM word is packed {I[31:16], Q[15:0]}, both signed 16-bit. The table is circular.

Parameters:
- ADDR_W, 10, RAM address width; the table length is 2**ADDR_W.
- DATA_W, 32, RAM word width; it is two lanes of DATA_W/2.
- FRAC_W, 16, fractional bits of the phase.
- CNT_W, 16, width of the output-sample count.

Ports:
- clk  in  1  single clock; the RAM rd_clk is tied to it.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- start_phase  in  ADDR_W+FRAC_W  initial phase {int,frac}.
- step  in  ADDR_W+FRAC_W  phase increment per output.
- num_out  in  CNT_W  number of outputs to produce.
- busy  out  1  high from start acceptance until the done pulse.
- done  out  1  one-cycle pulse at end of job.
- rd_addr  out  ADDR_W  RAM read address.
- rd_data  in  DATA_W  RAM read data, valid 1 cycle after rd_addr.
- out_data  out  DATA_W  interpolated {I,Q}.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream ready.
- out_last  out  1  marks the final sample of a job; qualified by out_valid.

Behaviour:
- Reset: state IDLE; busy, done, out_valid and out_last are 0; out_data is 0; rd_addr is 0; all internal registers are 0.
- Start: in IDLE, start=1 latches start_phase into phase, step, and num_out into remain.
  - If num_out=0, go to DONE and emit no samples.
  - Otherwise go to FETCH_A.
  - start is ignored when not in IDLE.
- FSM, all registered:
  - IDLE: wait for start.
  - FETCH_A: rd_addr=phase[int].
  - FETCH_B: rd_addr=phase[int]+1, wrapping mod 2**ADDR_W; register a=rd_data.
  - WAIT_B: register b=rd_data.
  - CALC: register the per-lane result into out_data; out_last=(remain==1).
  - OUT: out_valid=1. On out_valid&&out_ready: phase+=step (wraps mod 2**(ADDR_W+FRAC_W)) and remain-=1. Then go to DONE if remain was 1, else to FETCH_A.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- Timing: out_valid rises on the 4th clock edge after the edge that accepted start. Steady-state cadence is 5 cycles per sample with out_ready held high.
- Backpressure: while in OUT with out_ready=0, out_data, out_last and out_valid are held stable. No RAM reads are issued.
- Per-lane arithmetic:
  - diff = sext17(b) - sext17(a).
  - prod = diff * $signed({1'b0,frac}), 34-bit signed.
  - y = a + (prod >>> FRAC_W), an arithmetic shift (floor).
  - frac<1 keeps y within [min(a,b), max(a,b)], so no saturation logic is needed.
- frac=0 returns a exactly.
- Address wrap: phase int=2**ADDR_W-1 reads addresses 1023 then 0.
- Reset mid-job: immediate return to IDLE. No done pulse, no output, and out_valid drops asynchronously.
- The RAM may be written during a job. Data coherency is the caller's responsibility.

Decomposition:
- Package interp_pkg holds:
  - ADDR_W, DATA_W, FRAC_W and CNT_W defaults.
  - LANE_W=DATA_W/2.
  - The state enum {IDLE,FETCH_A,FETCH_B,WAIT_B,CALC,OUT,DONE}.
- Sub-module interp_lerp_lane (combinational, LANE_W/FRAC_W parameterised): inputs a, b, frac; output y. It is instanced twice, for I and Q.
- The top level owns the FSM, phase accumulator, counter and output register.

Test Plan:
- Midpoint:
  - Stimulus: RAM[5]={100,-200}, RAM[6]={300,200}; start_phase=0x58000, step=0, num_out=1.
  - Response: out_data={200,0}, out_last=1; done pulses 1 cycle after the handshake; busy falls with it.
- Wrap-around:
  - Stimulus: RAM[1023]={0,0}, RAM[0]={400,-400}; start_phase={1023,0x4000}.
  - Response: rd_addr sequence 1023 then 0; out_data={100,-100}.
- Floor rounding:
  - Stimulus: RAM[2]={0,0}, RAM[3]={-1,1}; phase={2,0x8000}.
  - Response: out_data={-1,0}.
- Streaming with backpressure:
  - Stimulus: ramp RAM[k]={k,-k}; start_phase=0, step=0x18000 (1.5), num_out=4; hold out_ready low for 5 cycles on the 2nd sample.
  - Response: outputs I=0,1,3,4 (the 3rd sample is I=3, Q=-3); the held sample stays stable; out_last only on the 4th sample; cadence is 5 cycles when ready.
- Zero count and ignored start:
  - Stimulus A: num_out=0.
  - Response A: done on the cycle after start; out_valid never asserts.
  - Stimulus B: start pulsed while busy.
  - Response B: no effect on the job in progress.
- Async reset mid-job:
  - Stimulus: assert rst_n=0 during WAIT_B.
  - Response: out_valid=0, busy=0, done=0 immediately; after release the block accepts a new start and produces correct results.
